// File: rtl/ser_pkg.sv
// Shared types for the parallel-to-serial word feeder.
package ser_pkg;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } ser_state_t;

endpackage

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: takes WIDTH-bit words on valid/ready and emits
// them one bit per cycle, chaining back-to-back words into a gapless stream.
module serial_word_feeder
   import ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             hold,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

   logic shifting;
   logic last_bit;
   logic xfer;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      ser_out    = 1'b0;

      shifting   = (state_q == S_SHIFT);
      last_bit   = (bit_cnt_q == LAST_IDX);
      busy       = shifting;
      in_ready   = !shifting || (last_bit && !hold);
      xfer       = in_valid && in_ready;
      ser_valid  = shifting && !hold;
      word_start = ser_valid && (bit_cnt_q == '0);

      if (shifting) begin
         ser_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
      end

      if (shifting && !hold) begin
         shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
         if (last_bit) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end

      // A load on the last bit overrides the drop to idle, keeping the stream gapless.
      if (xfer) begin
         shift_d   = in_data;
         bit_cnt_d = '0;
         state_d   = S_SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shift_q <= '0;
      else        shift_q <= shift_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bit_cnt_q <= '0;
      else        bit_cnt_q <= bit_cnt_d;
   end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: an MSB-first and an LSB-first
// instance share stimulus; outputs are checked against hand-computed bits.
module tb_serial_word_feeder;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       hold;

   logic m_in_ready, m_ser_out, m_ser_valid, m_word_start, m_busy;
   logic l_in_ready, l_ser_out, l_ser_valid, l_word_start, l_busy;

   int total;
   int bad;

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (m_in_ready),
      .hold       (hold),
      .ser_out    (m_ser_out),
      .ser_valid  (m_ser_valid),
      .word_start (m_word_start),
      .busy       (m_busy)
   );

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (l_in_ready),
      .hold       (hold),
      .ser_out    (l_ser_out),
      .ser_valid  (l_ser_valid),
      .word_start (l_word_start),
      .busy       (l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge so registered state is settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ser_valid"}, 32'(m_ser_valid), 32'd0);
      chk({tag, ".in_ready"},  32'(m_in_ready),  32'd1);
      chk({tag, ".busy"},      32'(m_busy),      32'd0);
      chk({tag, ".ser_out"},   32'(m_ser_out),   32'd0);
   endtask

   logic [15:0] exp_bits;
   logic [7:0]  word;
   logic [3:0]  det;
   logic        det_hit;
   int          valid_cnt;

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      hold     = 1'b0;
      #1;
      chk_idle("reset");
      chk("reset.lsb_valid", 32'(l_ser_valid), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single word 8'hB4, MSB first.
      in_valid = 1'b1;
      in_data  = 8'hB4;
      #1;
      chk("single.ready_idle", 32'(m_in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = 8'hFF;
      word     = 8'hB4;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("single.bit%0d", i),   32'(m_ser_out),    32'(word[7-i]));
         chk($sformatf("single.valid%0d", i), 32'(m_ser_valid),  32'd1);
         chk($sformatf("single.start%0d", i), 32'(m_word_start), 32'(i == 0));
         chk($sformatf("single.ready%0d", i), 32'(m_in_ready),   32'(i == 7));
         step();
      end
      #1;
      chk_idle("single.after");

      // Back-to-back 8'hA5 then 8'h0F with in_valid held high.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step();
      in_data  = 8'h0F;
      exp_bits = 16'hA50F;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) in_valid = 1'b0;
         #1;
         chk($sformatf("b2b.bit%0d", i),   32'(m_ser_out),    32'(exp_bits[15-i]));
         chk($sformatf("b2b.valid%0d", i), 32'(m_ser_valid),  32'd1);
         chk($sformatf("b2b.start%0d", i), 32'(m_word_start), 32'(i == 0 || i == 8));
         chk($sformatf("b2b.ready%0d", i), 32'(m_in_ready),   32'(i == 7 || i == 15));
         step();
      end
      #1;
      chk_idle("b2b.after");

      // hold for 3 cycles on bit 3 of 8'hB4.
      in_valid = 1'b1;
      in_data  = 8'hB4;
      step();
      in_valid  = 1'b0;
      word      = 8'hB4;
      valid_cnt = 0;
      for (int c = 0; c < 11; c++) begin
         hold = (c >= 3 && c < 6);
         #1;
         if (m_ser_valid) valid_cnt++;
         chk($sformatf("hold.ready%0d", c), 32'(m_in_ready), 32'(c == 10));
         chk($sformatf("hold.valid%0d", c), 32'(m_ser_valid), 32'(!hold));
         chk($sformatf("hold.bit%0d", c), 32'(m_ser_out),
             32'(word[7 - ((c < 3) ? c : (c < 6) ? 3 : c - 3)]));
         step();
      end
      hold = 1'b0;
      #1;
      chk("hold.valid_total", 32'(valid_cnt), 32'd8);
      chk_idle("hold.after");
      hold = 1'b1;
      #1;
      chk("hold.idle_ready", 32'(m_in_ready), 32'd1);
      hold = 1'b0;

      // hold on the last bit with a word waiting.
      in_valid = 1'b1;
      in_data  = 8'hB4;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      in_valid = 1'b1;
      in_data  = 8'hC3;
      hold     = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hlast.ready%0d", c), 32'(m_in_ready),  32'd0);
         chk($sformatf("hlast.valid%0d", c), 32'(m_ser_valid), 32'd0);
         chk($sformatf("hlast.busy%0d", c),  32'(m_busy),      32'd1);
         step();
      end
      hold = 1'b0;
      #1;
      chk("hlast.ready_release", 32'(m_in_ready), 32'd1);
      chk("hlast.last_bit",      32'(m_ser_out),  32'd0);
      step();
      in_valid = 1'b0;
      word     = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("hlast.next_bit%0d", i),   32'(m_ser_out),    32'(word[7-i]));
         chk($sformatf("hlast.next_start%0d", i), 32'(m_word_start), 32'(i == 0));
         step();
      end
      #1;
      chk_idle("hlast.after");

      // LSB-first instance: 8'hB4 then 8'h0B, with a bench-side "1011" detector.
      in_valid = 1'b1;
      in_data  = 8'hB4;
      step();
      in_data  = 8'h0B;
      exp_bits = {8'h0B, 8'hB4};
      det      = 4'h0;
      det_hit  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) in_valid = 1'b0;
         #1;
         chk($sformatf("lsb.bit%0d", i),   32'(l_ser_out),   32'(exp_bits[i]));
         chk($sformatf("lsb.valid%0d", i), 32'(l_ser_valid), 32'd1);
         if (l_ser_valid) begin
            det = {det[2:0], l_ser_out};
            if (det == 4'b1011) det_hit = 1'b1;
         end
         step();
      end
      #1;
      chk("lsb.detect_1011", 32'(det_hit), 32'd1);
      chk("lsb.idle_after", 32'(l_ser_valid), 32'd0);

      // Reset in the middle of a word; nothing replays afterwards.
      in_valid = 1'b1;
      in_data  = 8'hB4;
      step();
      in_valid = 1'b0;
      step();
      step();
      #1;
      chk("rstmid.busy_before", 32'(m_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_idle("rstmid.async");
      step();
      chk_idle("rstmid.next");
      rst_n = 1'b1;
      step();
      step();
      #1;
      chk_idle("rstmid.no_replay");
      chk("rstmid.lsb_valid", 32'(l_ser_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
